pixel_port_arbiter: RTL and testbench

Shares the single VGA adapter pixel-write port between sprite/screen drawers: user ship, enemy grid, bullet and title/end screen. Each drawer streams pixels as a burst with valid/ready and a last flag. The arbiter grants one drawer per burst, registers its pixel onto the adapter inputs, and clips off-screen pixels. It replaces the per-state output muxing in the game datapath, so drawers can run without the main control sequencing every write.

---
 rtl/pixel_port_arbiter_pkg.sv | 28 ++
 rtl/pixel_port_arbiter_rr_picker.sv | 50 +++++
 rtl/pixel_port_arbiter.sv | 135 +++++++++++++
 tb/tb_pixel_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_port_arbiter_pkg
// Description : Shared constants for the VGA pixel-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_port_arbiter_pkg;

    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int C_W   = 3;

    localparam int REQ_IDX_W  = 2;
    localparam int REQ_SCREEN = 0;
    localparam int REQ_USER   = 1;
    localparam int REQ_BULLET = 2;
    localparam int REQ_ENEMY  = 3;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;

endpackage

`default_nettype wire

// File: rtl/pixel_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : pixel_port_arbiter_rr_picker
// Description : Combinational winner pick, round-robin from a pointer or
//               fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_port_arbiter_rr_picker
    import pixel_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic [NUM_REQ-1:0]   i_valid,
    input  logic [REQ_IDX_W-1:0] i_rr_ptr,
    output logic [REQ_IDX_W-1:0] o_winner,
    output logic                 o_any_valid
);

    localparam logic [REQ_IDX_W:0] c_NUM = (REQ_IDX_W+1)'(NUM_REQ);

    logic [REQ_IDX_W:0]   w_sum;
    logic [REQ_IDX_W-1:0] w_idx;

    always_comb begin
        o_winner    = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (FIXED_PRIO != 0) begin
                w_sum = (REQ_IDX_W+1)'(k);
            end else begin
                // Pointer plus offset, folded back into 0..NUM_REQ-1
                w_sum = {1'b0, i_rr_ptr} + (REQ_IDX_W+1)'(k);
                if (w_sum >= c_NUM) begin
                    w_sum = w_sum - c_NUM;
                end
            end
            w_idx = w_sum[REQ_IDX_W-1:0];
            if (!o_any_valid && i_valid[w_idx]) begin
                o_any_valid = 1'b1;
                o_winner    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_port_arbiter
// Description : Grants the VGA adapter pixel port to one drawer per burst,
//               registers the pixel and clips off-screen coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int X_W        = pixel_port_arbiter_pkg::X_W,
    parameter int Y_W        = pixel_port_arbiter_pkg::Y_W,
    parameter int C_W        = pixel_port_arbiter_pkg::C_W,
    parameter int H_RES      = pixel_port_arbiter_pkg::H_RES,
    parameter int V_RES      = pixel_port_arbiter_pkg::V_RES,
    parameter int FIXED_PRIO = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     burst_done,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic [1:0]             grant_id,
    output logic                   busy
);

    import pixel_port_arbiter_pkg::*;

    localparam logic [X_W:0]           c_H_LIM    = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]           c_V_LIM    = (Y_W+1)'(V_RES);
    localparam logic [REQ_IDX_W-1:0]   c_LAST_IDX = REQ_IDX_W'(NUM_REQ-1);

    logic [1:0]           r_state;
    logic [REQ_IDX_W-1:0] r_rr_ptr;
    logic [REQ_IDX_W-1:0] r_grant;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [C_W-1:0]       r_colour;
    logic                 r_plot;
    logic [NUM_REQ-1:0]   r_done;

    logic [X_W-1:0]       w_x      [NUM_REQ];
    logic [Y_W-1:0]       w_y      [NUM_REQ];
    logic [C_W-1:0]       w_colour [NUM_REQ];
    logic [REQ_IDX_W-1:0] w_winner;
    logic                 w_any_valid;
    logic                 w_burst;
    logic                 w_hs;
    logic                 w_in_view;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic [REQ_IDX_W-1:0] w_next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_x[gi]      = req_x[gi*X_W +: X_W];
            assign w_y[gi]      = req_y[gi*Y_W +: Y_W];
            assign w_colour[gi] = req_colour[gi*C_W +: C_W];
        end
    endgenerate

    pixel_port_arbiter_rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_picker (
        .i_valid     (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any_valid (w_any_valid)
    );

    assign w_burst    = (r_state == ST_BURST);
    assign w_hs       = w_burst & req_valid[r_grant];
    assign w_grant_oh = NUM_REQ'(1) << r_grant;
    // Unsigned compare at one extra bit so H_RES/V_RES equal to 2**W still work
    assign w_in_view  = ({1'b0, w_x[r_grant]} < c_H_LIM) &&
                        ({1'b0, w_y[r_grant]} < c_V_LIM);
    assign w_next_ptr = (r_grant == c_LAST_IDX) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= C_W'(COLOUR_BLACK);
            r_plot   <= 1'b0;
            r_done   <= '0;
        end else begin
            r_plot <= 1'b0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant <= w_winner;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        r_x      <= w_x[r_grant];
                        r_y      <= w_y[r_grant];
                        r_colour <= w_colour[r_grant];
                        r_plot   <= w_in_view;
                        if (req_last[r_grant]) begin
                            r_done   <= w_grant_oh;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = w_burst ? w_grant_oh : '0;
    assign burst_done = r_done;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;
    assign grant_id   = 2'(r_grant);
    assign busy       = w_burst;

endmodule

`default_nettype wire

// File: tb/tb_pixel_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_port_arbiter
// Description : Self-checking bench: vector table, directed sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [35:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [11:0] req_colour = '0;

    logic [3:0] rr_ready, rr_done, fp_ready, fp_done;
    logic [8:0] rr_x, fp_x;
    logic [7:0] rr_y, fp_y;
    logic [2:0] rr_c, fp_c;
    logic       rr_plot, fp_plot, rr_busy, fp_busy;
    logic [1:0] rr_grant, fp_grant;

    always #5 clk = ~clk;

    pixel_port_arbiter #(.FIXED_PRIO(0)) u_dut_rr (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(rr_ready), .burst_done(rr_done), .vga_x(rr_x), .vga_y(rr_y),
        .vga_colour(rr_c), .vga_plot(rr_plot), .grant_id(rr_grant), .busy(rr_busy)
    );

    pixel_port_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(fp_ready), .burst_done(fp_done), .vga_x(fp_x), .vga_y(fp_y),
        .vga_colour(fp_c), .vga_plot(fp_plot), .grant_id(fp_grant), .busy(fp_busy)
    );

    typedef struct { int x; int y; int c; bit last; } px_t;
    typedef struct {
        int valid; int last; int x; int y; int c;
        int e_ready; int e_plot; int e_x; int e_y; int e_c; int e_done; int e_busy; int e_grant;
    } vec_t;

    px_t  q[4][$];
    logic [3:0] force_stall = '0;
    bit   rand_en = 1'b0;
    bit   use_fp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   order[$];
    logic [3:0] s_ready;
    int   s_plot, s_grant;

    // Reference model: owner is the requester holding the port, -1 when free
    int m_owner, m_ptr, m_grant, m_x, m_y, m_c, m_plot, m_done;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input bit fixed, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = fixed ? k : (ptr + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_grant = 0;
        m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_done = 0;
    endtask

    task automatic push_burst(input int id, input int len, input int x0, input int y, input int c);
        px_t p;
        for (int k = 0; k < len; k++) begin
            p.x = x0 + k; p.y = y; p.c = c; p.last = (k == len - 1);
            q[id].push_back(p);
        end
    endtask

    function automatic px_t rand_px(input bit last);
        px_t p;
        p.x = ($urandom % 2 == 0) ? int'($urandom_range(310, 330)) : int'($urandom_range(0, 511));
        p.y = ($urandom % 2 == 0) ? int'($urandom_range(232, 250)) : int'($urandom_range(0, 255));
        p.c = int'($urandom_range(0, 7));
        p.last = last;
        return p;
    endfunction

    task automatic apply_inputs();
        bit st;
        for (int i = 0; i < 4; i++) begin
            st = rand_en ? ($urandom % 4 == 0) : force_stall[i];
            if (q[i].size() > 0 && !st) begin
                req_valid[i]        = 1'b1;
                req_last[i]         = q[i][0].last;
                req_x[i*9 +: 9]     = 9'(q[i][0].x);
                req_y[i*8 +: 8]     = 8'(q[i][0].y);
                req_colour[i*3 +: 3] = 3'(q[i][0].c);
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        int n_owner, n_ptr, n_grant, n_x, n_y, n_c, n_plot, n_done, hs, p, len;
        logic [3:0] d_ready, d_done;
        int exp_ready;
        apply_inputs();
        @(negedge clk);
        d_ready = use_fp ? fp_ready : rr_ready;
        d_done  = use_fp ? fp_done : rr_done;
        s_ready = d_ready;
        s_plot  = use_fp ? int'(fp_plot) : int'(rr_plot);
        s_grant = use_fp ? int'(fp_grant) : int'(rr_grant);
        exp_ready = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("ready", int'(d_ready), exp_ready);
        chk("plot", s_plot, m_plot);
        chk("vga_x", use_fp ? int'(fp_x) : int'(rr_x), m_x);
        chk("vga_y", use_fp ? int'(fp_y) : int'(rr_y), m_y);
        chk("colour", use_fp ? int'(fp_c) : int'(rr_c), m_c);
        chk("burst_done", int'(d_done), m_done);
        chk("busy", use_fp ? int'(fp_busy) : int'(rr_busy), (m_owner >= 0) ? 1 : 0);
        chk("grant_id", s_grant, m_grant);
        for (int i = 0; i < 4; i++) if (d_done[i]) order.push_back(i);

        n_owner = m_owner; n_ptr = m_ptr; n_grant = m_grant;
        n_x = m_x; n_y = m_y; n_c = m_c; n_plot = 0; n_done = 0; hs = -1;
        if (m_owner < 0) begin
            p = pick(req_valid, use_fp, m_ptr);
            if (p >= 0) begin n_owner = p; n_grant = p; end
        end else if (req_valid[m_owner]) begin
            hs = m_owner;
            n_x = q[hs][0].x; n_y = q[hs][0].y; n_c = q[hs][0].c;
            n_plot = (n_x < 320 && n_y < 240) ? 1 : 0;
            if (q[hs][0].last) begin
                n_done = 1 << hs; n_ptr = (hs + 1) % 4; n_owner = -1;
            end
        end
        @(posedge clk);
        #1;
        m_owner = n_owner; m_ptr = n_ptr; m_grant = n_grant;
        m_x = n_x; m_y = n_y; m_c = n_c; m_plot = n_plot; m_done = n_done;
        if (hs >= 0) void'(q[hs].pop_front());
        if (rand_en) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0 && $urandom % 6 == 0) begin
                    len = int'($urandom_range(1, 4));
                    for (int k = 0; k < len; k++) q[i].push_back(rand_px(k == len - 1));
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req_valid = '0; req_last = '0;
        for (int i = 0; i < 4; i++) q[i].delete();
        force_stall = '0;
        rand_en = 1'b0;
        order.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic run_order(input int want, input int budget);
        int cyc;
        cyc = 0;
        while (order.size() < want && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic chk_order(input string name, input int e0, input int e1, input int e2, input int n);
        int e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({name, "_len"}, order.size(), n);
        for (int k = 0; k < n; k++)
            if (order.size() > k) chk(name, order[k], e[k]);
    endtask

    vec_t vecs[11];

    initial begin
        int cyc;
        vecs[0]  = '{2, 0, 10, 220, 3,   0, 0, 0, 0, 0,       0, 0, 0};
        vecs[1]  = '{2, 0, 10, 220, 3,   2, 0, 0, 0, 0,       0, 1, 1};
        vecs[2]  = '{2, 0, 11, 220, 3,   2, 1, 10, 220, 3,    0, 1, 1};
        vecs[3]  = '{2, 1, 12, 220, 3,   2, 1, 11, 220, 3,    0, 1, 1};
        vecs[4]  = '{0, 0, 0, 0, 0,      0, 1, 12, 220, 3,    2, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0,      0, 0, 12, 220, 3,    0, 0, 1};
        vecs[6]  = '{2, 0, 320, 10, 5,   0, 0, 12, 220, 3,    0, 0, 1};
        vecs[7]  = '{2, 0, 320, 10, 5,   2, 0, 12, 220, 3,    0, 1, 1};
        vecs[8]  = '{2, 0, 5, 240, 6,    2, 0, 320, 10, 5,    0, 1, 1};
        vecs[9]  = '{2, 1, 319, 239, 7,  2, 0, 5, 240, 6,     0, 1, 1};
        vecs[10] = '{0, 0, 0, 0, 0,      0, 1, 319, 239, 7,   2, 0, 1};

        // Single burst from requester 1 followed by clipping cases
        do_reset();
        use_fp = 1'b0;
        for (int r = 0; r < 11; r++) begin
            req_valid       = 4'(vecs[r].valid);
            req_last        = (vecs[r].last != 0) ? 4'b0010 : 4'b0000;
            req_x[9 +: 9]   = 9'(vecs[r].x);
            req_y[8 +: 8]   = 8'(vecs[r].y);
            req_colour[3 +: 3] = 3'(vecs[r].c);
            @(negedge clk);
            chk("tbl_ready", int'(rr_ready), vecs[r].e_ready);
            chk("tbl_plot", int'(rr_plot), vecs[r].e_plot);
            chk("tbl_x", int'(rr_x), vecs[r].e_x);
            chk("tbl_y", int'(rr_y), vecs[r].e_y);
            chk("tbl_colour", int'(rr_c), vecs[r].e_c);
            chk("tbl_done", int'(rr_done), vecs[r].e_done);
            chk("tbl_busy", int'(rr_busy), vecs[r].e_busy);
            chk("tbl_grant", int'(rr_grant), vecs[r].e_grant);
            @(posedge clk);
            #1;
        end

        // Round-robin contention between requesters 2 and 3
        do_reset();
        push_burst(2, 2, 40, 50, 1);
        push_burst(3, 2, 60, 70, 2);
        push_burst(2, 2, 80, 90, 4);
        run_order(3, 40);
        chk_order("rr_order", 2, 3, 2, 3);

        // Stall mid-burst while another requester waits
        do_reset();
        push_burst(1, 5, 100, 100, 6);
        cyc = 0;
        while (q[1].size() > 3 && cyc < 20) begin tick(); cyc++; end
        chk("stall_setup", q[1].size(), 3);
        push_burst(0, 1, 7, 7, 7);
        force_stall = 4'b0010;
        tick();
        chk("stall_grant", s_grant, 1);
        chk("stall_ready", int'(s_ready), 2);
        tick();
        chk("stall_plot", s_plot, 0);
        chk("stall_grant", s_grant, 1);
        chk("stall_ready", int'(s_ready), 2);
        force_stall = '0;
        tick();
        chk("stall_plot", s_plot, 0);
        run_order(2, 30);
        chk_order("stall_order", 1, 0, 0, 2);

        // Fixed priority: requester 0 wins although round-robin would pick 3
        do_reset();
        use_fp = 1'b1;
        push_burst(0, 1, 1, 1, 1);
        run_order(1, 20);
        order.delete();
        push_burst(0, 3, 20, 20, 3);
        push_burst(3, 2, 30, 30, 5);
        cyc = 0;
        while (order.size() < 2 && cyc < 30) begin
            tick();
            cyc++;
            if (order.size() == 0) chk("fp_ready3", int'(s_ready[3]), 0);
        end
        chk_order("fp_order", 0, 3, 0, 2);

        // Asynchronous reset in the middle of a burst
        do_reset();
        use_fp = 1'b0;
        push_burst(1, 1, 2, 2, 2);
        run_order(1, 20);
        push_burst(1, 5, 200, 30, 3);
        cyc = 0;
        while (q[1].size() > 3 && cyc < 20) begin tick(); cyc++; end
        chk("rst_setup", q[1].size(), 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_x", int'(rr_x), 0);
        chk("rst_y", int'(rr_y), 0);
        chk("rst_colour", int'(rr_c), 0);
        chk("rst_plot", int'(rr_plot), 0);
        chk("rst_done", int'(rr_done), 0);
        chk("rst_busy", int'(rr_busy), 0);
        chk("rst_grant", int'(rr_grant), 0);
        chk("rst_ready", int'(rr_ready), 0);
        for (int i = 0; i < 4; i++) q[i].delete();
        model_reset();
        order.delete();
        apply_inputs();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push_burst(3, 1, 9, 9, 1);
        push_burst(1, 1, 8, 8, 2);
        run_order(2, 20);
        chk_order("rst_order", 1, 3, 0, 2);

        // Randomized traffic, both arbitration modes
        do_reset();
        use_fp = 1'b0;
        rand_en = 1'b1;
        repeat (600) tick();
        do_reset();
        use_fp = 1'b1;
        rand_en = 1'b1;
        repeat (600) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
